// File: rtl/lt24_dct_pkg.sv
// Shared constants and state encoding for the DCT trace packer.
// Symbols are packed LSB-first into fixed-width words.
package lt24_dct_pkg;

  localparam int DCT_SYM_W = 2;
  localparam int DCT_DEPTH = 15;
  localparam int DCT_BUF_W = 30;
  localparam int DCT_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    ENDED = 2'd2
  } dct_state_e;

endpackage

// File: rtl/lt24_dct_trace_packer.sv
// Packs 2-bit trace symbols into 30-bit words behind a one-deep output slot,
// with a flush-and-stop sequence driven by test_ending.
module lt24_dct_trace_packer
  import lt24_dct_pkg::*;
#(
  parameter int SYM_W = DCT_SYM_W,
  parameter int DEPTH = DCT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trace_valid,
  input  logic [SYM_W-1:0]       trace_data,
  output logic                   trace_ready,
  output logic [SYM_W*DEPTH-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0]   dct_count,
  output logic                   dct_valid,
  input  logic                   dct_ready,
  input  logic                   test_ending,
  output logic                   test_has_ended,
  output logic [15:0]            words_sent
);

  localparam int BUF_W = SYM_W * DEPTH;
  localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(DEPTH);

  dct_state_e             state_q, state_d;
  logic [BUF_W-1:0]       acc_q, acc_d;
  logic [DCT_CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [DCT_CNT_W-1:0]   wr_pos;
  logic [DCT_CNT_W-1:0]   load_cnt;
  logic                   slot_free;
  logic                   load;
  logic                   accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      acc_q     <= '0;
      acc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    wr_pos      = acc_cnt_q;
    load        = 1'b0;
    load_cnt    = '0;
    trace_ready = 1'b0;
    slot_free   = !dct_valid || dct_ready;

    case (state_q)
      RUN: begin
        trace_ready = (acc_cnt_q != FULL_CNT) || slot_free;
        if ((acc_cnt_q == FULL_CNT) && slot_free) begin
          load     = 1'b1;
          load_cnt = FULL_CNT;
        end
        if (test_ending) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Partial words drain first; only an empty accumulator may end the test.
        if (slot_free) begin
          if (acc_cnt_q != '0) begin
            load     = 1'b1;
            load_cnt = acc_cnt_q;
          end else begin
            state_d = ENDED;
          end
        end
      end
      ENDED: begin
        state_d = ENDED;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    accept = trace_valid && trace_ready;

    // Unwritten positions stay zero, so a flushed partial word is zero-padded.
    if (load) begin
      acc_d     = '0;
      acc_cnt_d = '0;
      wr_pos    = '0;
    end

    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_pos == DCT_CNT_W'(i)) begin
          acc_d[i*SYM_W +: SYM_W] = trace_data;
        end
      end
      acc_cnt_d = wr_pos + DCT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      dct_valid  <= 1'b0;
    end else if (load) begin
      dct_buffer <= acc_q;
      dct_count  <= load_cnt;
      dct_valid  <= 1'b1;
    end else if (dct_ready) begin
      dct_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      words_sent <= '0;
    end else if (dct_valid && dct_ready && (words_sent != 16'hFFFF)) begin
      words_sent <= words_sent + 16'd1;
    end
  end

  assign test_has_ended = (state_q == ENDED);

endmodule

// File: tb/tb_lt24_dct_trace_packer.sv
// Directed bench for the DCT trace packer; emitted words are captured by a
// handshake monitor and compared against hand-computed values.
module tb_lt24_dct_trace_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_valid;
  logic [1:0]  trace_data;
  logic        trace_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
  logic        test_ending;
  logic        test_has_ended;
  logic [15:0] words_sent;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] words_q[$];

  lt24_dct_trace_packer #(.SYM_W(2), .DEPTH(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .trace_valid    (trace_valid),
    .trace_data     (trace_data),
    .trace_ready    (trace_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .words_sent     (words_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && dct_valid && dct_ready) begin
      words_q.push_back({dct_count, dct_buffer});
    end
  end

  task automatic check_val(input string tag, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    trace_valid = 1'b0;
    trace_data  = 2'd0;
    dct_ready   = 1'b0;
    test_ending = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    words_q.delete();
  endtask

  task automatic wait_words(input int n, input string tag);
    int k = 0;
    while (words_q.size() < n && k < 50) begin
      tick();
      k++;
    end
    check_val({tag, "_nwords"}, 34'(words_q.size()), 34'(n));
  endtask

  task automatic pop_word(input string tag, input logic [3:0] exp_cnt, input logic [29:0] exp_buf);
    logic [33:0] w;
    w = (words_q.size() > 0) ? words_q.pop_front() : 34'bx;
    check_val(tag, w, {exp_cnt, exp_buf});
  endtask

  task automatic wait_ended(input string tag);
    int k = 0;
    while (!test_has_ended && k < 20) begin
      tick();
      k++;
    end
    check_val({tag, "_ended"}, 34'(test_has_ended), 34'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int cyc;
    int drops;

    // Reset values
    do_reset();
    check_val("rst_trace_ready", 34'(trace_ready), 34'd1);
    check_val("rst_dct_valid", 34'(dct_valid), 34'd0);
    check_val("rst_dct_count", 34'(dct_count), 34'd0);
    check_val("rst_dct_buffer", 34'(dct_buffer), 34'd0);
    check_val("rst_has_ended", 34'(test_has_ended), 34'd0);
    check_val("rst_words_sent", 34'(words_sent), 34'd0);

    // One full word of 0,1,2,3,...
    dct_ready   = 1'b1;
    trace_valid = 1'b1;
    drops = 0;
    for (int i = 0; i < 15; i++) begin
      trace_data = 2'(i % 4);
      #1;
      if (!trace_ready) drops++;
      tick();
    end
    trace_valid = 1'b0;
    check_val("t31_drops", 34'(drops), 34'd0);
    wait_words(1, "t31");
    pop_word("t31_word", 4'd15, 30'h24E4E4E4);
    tick();
    check_val("t31_words_sent", 34'(words_sent), 34'd1);
    check_val("t31_valid_clear", 34'(dct_valid), 34'd0);

    // Back-to-back 3s: no stall at the word boundary
    do_reset();
    dct_ready   = 1'b1;
    trace_valid = 1'b1;
    trace_data  = 2'd3;
    drops = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (!trace_ready) drops++;
      tick();
    end
    trace_valid = 1'b0;
    check_val("t32_drops", 34'(drops), 34'd0);
    wait_words(2, "t32");
    pop_word("t32_word0", 4'd15, 30'h3FFFFFFF);
    pop_word("t32_word1", 4'd15, 30'h3FFFFFFF);

    // Backpressure: 30 accepted, 31st stalls until dct_ready
    do_reset();
    dct_ready   = 1'b0;
    trace_valid = 1'b1;
    acc = 0;
    cyc = 0;
    while (acc < 30 && cyc < 80) begin
      trace_data = 2'(acc % 4);
      #1;
      if (trace_ready) acc++;
      tick();
      cyc++;
    end
    check_val("t33_accepted", 34'(acc), 34'd30);
    trace_data = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("t33_stall_ready", 34'(trace_ready), 34'd0);
      check_val("t33_hold_word", {dct_count, dct_buffer}, {4'd15, 30'h24E4E4E4});
      check_val("t33_hold_valid", 34'(dct_valid), 34'd1);
      tick();
    end
    dct_ready = 1'b1;
    #1;
    check_val("t33_release_ready", 34'(trace_ready), 34'd1);
    tick();
    trace_valid = 1'b0;
    test_ending = 1'b1;
    wait_ended("t33");
    test_ending = 1'b0;
    check_val("t33_nwords", 34'(words_q.size()), 34'd3);
    pop_word("t33_word0", 4'd15, 30'h24E4E4E4);
    pop_word("t33_word1", 4'd15, 30'h13939393);
    pop_word("t33_word2", 4'd1, 30'h00000002);
    check_val("t33_words_sent", 34'(words_sent), 34'd3);

    // Flush of a partial word
    do_reset();
    dct_ready   = 1'b1;
    trace_valid = 1'b1;
    trace_data  = 2'd2;
    repeat (5) tick();
    trace_valid = 1'b0;
    test_ending = 1'b1;
    wait_ended("t34");
    trace_valid = 1'b1;
    #1;
    check_val("t34_ready_low", 34'(trace_ready), 34'd0);
    trace_valid = 1'b0;
    test_ending = 1'b0;
    check_val("t34_nwords", 34'(words_q.size()), 34'd1);
    pop_word("t34_word", 4'd5, 30'h000002AA);
    check_val("t34_words_sent", 34'(words_sent), 34'd1);

    // Empty flush: ended two edges later, nothing emitted
    do_reset();
    dct_ready   = 1'b1;
    test_ending = 1'b1;
    tick();
    check_val("t35_edge1", 34'(test_has_ended), 34'd0);
    tick();
    check_val("t35_edge2", 34'(test_has_ended), 34'd1);
    check_val("t35_no_valid", 34'(dct_valid), 34'd0);
    test_ending = 1'b0;
    tick();
    check_val("t35_sticky", 34'(test_has_ended), 34'd1);
    check_val("t35_nwords", 34'(words_q.size()), 34'd0);

    // Reset with a pending word and 7 buffered symbols
    do_reset();
    dct_ready   = 1'b0;
    trace_valid = 1'b1;
    for (int i = 0; i < 22; i++) begin
      trace_data = 2'(i % 4);
      tick();
    end
    trace_valid = 1'b0;
    check_val("t36_pending", 34'(dct_valid), 34'd1);
    reset = 1'b1;
    tick();
    check_val("t36_buffer", 34'(dct_buffer), 34'd0);
    check_val("t36_count", 34'(dct_count), 34'd0);
    check_val("t36_valid", 34'(dct_valid), 34'd0);
    check_val("t36_ended", 34'(test_has_ended), 34'd0);
    check_val("t36_words_sent", 34'(words_sent), 34'd0);
    check_val("t36_ready", 34'(trace_ready), 34'd1);
    reset     = 1'b0;
    dct_ready = 1'b1;
    repeat (5) tick();
    check_val("t36_post_valid", 34'(dct_valid), 34'd0);
    test_ending = 1'b1;
    wait_ended("t36");
    test_ending = 1'b0;
    check_val("t36_nwords", 34'(words_q.size()), 34'd0);
    check_val("t36_post_sent", 34'(words_sent), 34'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lt24_dct_trace_packer.md
LT24_DCT_TRACE_PACKER -- requirements
Module: lt24_dct_trace_packer

Interface
REQ-001 Parameters, one per line, SHALL be:
- SYM_W, 2, trace symbol width in bits.
- DEPTH, 15, symbols per packed word; SYM_W*DEPTH SHALL equal 30.
REQ-002 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 trace_valid  in  1  trace symbol present.
REQ-005 trace_data  in  2  trace symbol.
REQ-006 trace_ready  out  1  symbol accepted this cycle when high together with trace_valid.
REQ-007 dct_buffer  out  30  packed symbols; first-accepted symbol in bits [1:0], symbol i in bits [2i+1:2i].
REQ-008 dct_count  out  4  number of valid symbols in dct_buffer, 1..15.
REQ-009 dct_valid  out  1  dct_buffer/dct_count hold a word.
REQ-010 dct_ready  in  1  consumer takes the word when high together with dct_valid.
REQ-011 test_ending  in  1  level request to flush and stop.
REQ-012 test_has_ended  out  1  sticky; flush complete.
REQ-013 words_sent  out  16  count of completed output handshakes; saturates at 0xFFFF.

Function
REQ-014 Block SHALL hold a 30-bit accumulator with count acc_cnt (0..15) and one output slot (dct_buffer, dct_count, dct_valid).
REQ-015 slot_free SHALL be (!dct_valid || dct_ready).
REQ-016 FSM states SHALL be RUN, FLUSH, ENDED.
REQ-017 In RUN, trace_ready SHALL be (acc_cnt<15 || slot_free); in FLUSH and ENDED it SHALL be 0.
REQ-018 An accepted symbol SHALL be written at position acc_cnt and acc_cnt SHALL increment.
REQ-019 When acc_cnt==15 and slot_free, the slot SHALL load the accumulator with count 15 on that edge.
- acc_cnt SHALL clear; a symbol accepted on the same edge SHALL go to position 0, giving acc_cnt=1.
REQ-020 Output latency: dct_valid SHALL rise on the edge after the cycle in which acc_cnt==15 and slot_free.
- Sustained throughput SHALL be one symbol per cycle while dct_ready=1.
REQ-021 dct_buffer/dct_count SHALL be stable while dct_valid=1 and dct_ready=0.
- dct_valid SHALL clear after a handshake unless the slot is reloaded on the same edge.
REQ-022 RUN -> FLUSH SHALL occur on any edge with test_ending=1.
- A symbol accepted on that same edge SHALL be included in the flush.
REQ-023 In FLUSH, when acc_cnt>0 and slot_free, the slot SHALL load the partial word: count=acc_cnt, unused upper bits zero; acc_cnt SHALL clear.
REQ-024 FLUSH -> ENDED SHALL occur when acc_cnt==0 and slot_free; an empty word SHALL never be emitted.
REQ-025 In ENDED, test_has_ended SHALL be 1 and test_ending SHALL be ignored; only reset leaves ENDED.
REQ-026 words_sent SHALL increment on every edge with dct_valid && dct_ready, saturating at 0xFFFF.

Reset
REQ-027 On reset:
- state=RUN, acc_cnt=0, accumulator=0.
- dct_buffer=0, dct_count=0, dct_valid=0.
- test_has_ended=0, words_sent=0.
- trace_ready=1 in the first cycle after reset.
REQ-028 Reset mid-operation SHALL discard the accumulator and any pending word without emitting it.

Structure
REQ-029 A shared package lt24_dct_pkg SHALL hold:
- constants DCT_SYM_W=2, DCT_DEPTH=15, DCT_BUF_W=30, DCT_CNT_W=4;
- the state enum {RUN, FLUSH, ENDED}.
REQ-030 The block SHALL be a single module with no sub-module; the output slot is inline registers.

Verification
REQ-031 Stream 15 symbols 0,1,2,3,0,1,... with dct_ready=1 -> one word, dct_count=15, dct_buffer=30'h24E4E4E4; words_sent=1.
REQ-032 Stream 30 back-to-back symbols of 3 with dct_ready=1 -> trace_ready never drops; two words of 30'h3FFFFFFF, count 15.
REQ-033 dct_ready=0 while 31 symbols are offered -> trace_ready low after the 30th is accepted; first word held stable; dct_ready=1 then releases it with no symbol lost.
REQ-034 Accept 5 symbols of 2, then assert test_ending -> one word dct_count=5, dct_buffer=30'h000002AA; then test_has_ended=1 and trace_ready=0.
REQ-035 test_ending with acc_cnt=0 and empty slot -> test_has_ended=1 two edges later, no dct_valid.
REQ-036 Reset asserted with acc_cnt=7 and dct_valid=1 -> all outputs reach REQ-027 values on the next edge; no word emitted.
